hdmi_data_island_scheduler: RTL and testbench
=============================================

# hdmi_data_island_scheduler

Sequences HDMI data islands inside each horizontal blanking interval and drives the packet-selection datapath that supplies packet header/subpacket words. Tracks video-active/blanking transitions, sizes each island to the remaining blanking budget, and generates preamble, guard-band, packet-period and packet-advance strobes. Sits between the video timing generator and the packet picker / TERC4 encoder mux, all on the pixel clock.

## Interface

- MIN_CTRL, 12: control-period cycles after video end before an island may start
- VIDEO_RESERVE, 22: cycles that must remain after trailing guard (video preamble + guard + min control)
- MAX_PACKETS, 18: maximum packets per island (1..18)
- clk_pixel  in  1  pixel clock; sole clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  islands permitted; sampled only at the island decision cycle
- video_active  in  1  1 during video data period
- blank_cycles_left  in  16  blanking cycles remaining, current cycle inclusive; valid when video_active=0
- island_preamble  out  1  data-island preamble (CTL3..0 = 0101)
- data_guard  out  1  leading or trailing data-island guard band
- data_island_period  out  1  packet transmission cycle (TERC4 data)
- packet_enable  out  1  one-cycle strobe: picker latches next packet type
- packet_pixel_counter  out  5  cycle index within current packet, 0..31
- schedule_error  out  1  one-cycle pulse on timing violation

## Operation

- States: IDLE, ACTIVE, CTRL, PREAMBLE, LEAD_GUARD, PACKET, TRAIL_GUARD.
- IDLE: video_active=1 -> ACTIVE. No island is scheduled after reset until one full video period is seen.
- ACTIVE: video_active=0 -> CTRL, control counter cleared.
- CTRL: counts MIN_CTRL cycles. Decision on the last count cycle, with B = blank_cycles_left of that cycle: N = min(MAX_PACKETS, sat0(B - 13 - VIDEO_RESERVE) >> 5). 16-bit arithmetic; subtraction saturates at 0. If enable=1 and N>=1 -> PREAMBLE with N registered; otherwise -> IDLE (no island this line). video_active=1 during CTRL -> ACTIVE, no error.
- PREAMBLE: 8 cycles -> LEAD_GUARD. LEAD_GUARD: 2 cycles -> PACKET.
- PACKET: packet_pixel_counter 0..31 per packet; after packet N at counter 31 -> TRAIL_GUARD. TRAIL_GUARD: 2 cycles -> IDLE. One island per blanking interval.
- packet_enable: high on the last LEAD_GUARD cycle, and on counter==31 of packets 1..N-1. Never high on the final packet's counter 31 or outside islands. Exactly N strobes per island.
- Violation: video_active=1 in PREAMBLE, LEAD_GUARD, PACKET or TRAIL_GUARD -> schedule_error pulses for one cycle, then -> ACTIVE with the island aborted.
- enable falling mid-island has no effect; the island completes.

## Timing

- All outputs registered and decoded from state/counters; reset value of every output is 0. Reset to IDLE asynchronously at any point, including mid-island.
- With video_active falling at cycle t: CTRL spans t..t+MIN_CTRL-1, preamble starts at t+MIN_CTRL, and the first packet cycle (counter=0) is at t+MIN_CTRL+10.
- Island length is 12+32N cycles. With a correct B, the island ends at least VIDEO_RESERVE cycles before video_active rises.
- packet_pixel_counter is 0 outside PACKET and wraps 31->0 between packets.
- island_preamble, data_guard and data_island_period are mutually exclusive.

## Structure

- Shared package hdmi_island_pkg: state enum typedef, PREAMBLE_LEN=8, GUARD_LEN=2, PACKET_LEN=32, CTL_DATA_ISLAND_PREAMBLE=4'b0101.
- One sub-module, hdmi_island_budget: combinational N computation from B, VIDEO_RESERVE and MAX_PACKETS, verified standalone.

## Test plan

- B=100 at decision, defaults -> N=2: 8 preamble, 2 guard, 64 packet cycles, 2 guard; packet_enable exactly 2 strobes, at the last lead-guard cycle and at packet-1 counter 31.
- B=5000 -> N clamped to 18; island 588 cycles; 18 packet_enable strobes; returns to IDLE.
- B=66 (N=0) or enable=0 at the decision cycle -> no preamble or strobes; state returns to IDLE.
- video_active asserted at packet 1 counter 10 -> schedule_error one-cycle pulse; outputs 0 the next cycle; a new island is scheduled on the next blanking interval.
- Reset asserted mid-PACKET -> all outputs 0 immediately (async); no island until a video period followed by blanking.
- Blanking of only 8 cycles (video_active re-rises in CTRL) -> no island, no error.

Source files
------------

// File: rtl/hdmi_island_pkg.sv
// Shared types and timing constants for the HDMI data-island scheduler.
package hdmi_island_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_CTRL,
        ST_PREAMBLE,
        ST_LEAD_GUARD,
        ST_PACKET,
        ST_TRAIL_GUARD
    } island_state_t;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;
    localparam logic [3:0] CTL_DATA_ISLAND_PREAMBLE = 4'b0101;

    // Preamble + both guards + the decision cycle itself.
    localparam int BUDGET_OVERHEAD = PREAMBLE_LEN + 2 * GUARD_LEN + 1;

endpackage

// File: rtl/hdmi_island_budget.sv
// Sizes a data island: how many 32-cycle packets fit in the remaining blanking.
module hdmi_island_budget
    import hdmi_island_pkg::*;
#(
    parameter int VIDEO_RESERVE = 22,
    parameter int MAX_PACKETS   = 18
) (
    input  logic [15:0] blank_cycles,
    output logic [4:0]  num_packets
);

    localparam logic [15:0] OVERHEAD = 16'(BUDGET_OVERHEAD + VIDEO_RESERVE);
    localparam logic [10:0] MAX_N    = 11'(MAX_PACKETS);

    logic [15:0] spare;
    logic [10:0] slots;

    always_comb begin
        spare       = (blank_cycles > OVERHEAD) ? (blank_cycles - OVERHEAD) : 16'd0;
        slots       = 11'(spare >> 5);
        num_packets = (slots > MAX_N) ? 5'(MAX_PACKETS) : slots[4:0];
    end

endmodule

// File: rtl/hdmi_data_island_scheduler.sv
// Schedules one data island per horizontal blanking interval and drives the
// preamble / guard / packet-period / packet-advance strobes.
module hdmi_data_island_scheduler
    import hdmi_island_pkg::*;
#(
    parameter int MIN_CTRL      = 12,
    parameter int VIDEO_RESERVE = 22,
    parameter int MAX_PACKETS   = 18
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        enable,
    input  logic        video_active,
    input  logic [15:0] blank_cycles_left,
    output logic        island_preamble,
    output logic        data_guard,
    output logic        data_island_period,
    output logic        packet_enable,
    output logic [4:0]  packet_pixel_counter,
    output logic        schedule_error
);

    // The ACTIVE cycle that first sees blanking counts as control cycle one.
    localparam logic [4:0] CTRL_LAST  = 5'(MIN_CTRL - 2);
    localparam logic [4:0] PRE_LAST   = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0] GUARD_LAST = 5'(GUARD_LEN - 1);
    localparam logic [4:0] PKT_LAST   = 5'(PACKET_LEN - 1);

    island_state_t state, state_n;
    logic [4:0] cnt, cnt_n;
    logic [4:0] pkt, pkt_n;
    logic [4:0] num_pkts, num_pkts_n;
    logic [4:0] budget;
    logic       err_n;
    logic       in_island;

    hdmi_island_budget #(
        .VIDEO_RESERVE(VIDEO_RESERVE),
        .MAX_PACKETS  (MAX_PACKETS)
    ) u_budget (
        .blank_cycles(blank_cycles_left),
        .num_packets (budget)
    );

    assign in_island = (state == ST_PREAMBLE) || (state == ST_LEAD_GUARD) ||
                       (state == ST_PACKET)   || (state == ST_TRAIL_GUARD);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pkt_n      = pkt;
        num_pkts_n = num_pkts;
        err_n      = 1'b0;
        case (state)
            ST_IDLE: if (video_active) state_n = ST_ACTIVE;
            ST_ACTIVE: begin
                if (!video_active) begin
                    state_n = ST_CTRL;
                    cnt_n   = 5'd0;
                end
            end
            ST_CTRL: begin
                if (video_active) begin
                    state_n = ST_ACTIVE;
                end else if (cnt == CTRL_LAST) begin
                    cnt_n = 5'd0;
                    if (enable && budget != 5'd0) begin
                        state_n    = ST_PREAMBLE;
                        num_pkts_n = budget;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
            ST_PREAMBLE: begin
                cnt_n = cnt + 5'd1;
                if (cnt == PRE_LAST) begin
                    state_n = ST_LEAD_GUARD;
                    cnt_n   = 5'd0;
                end
            end
            ST_LEAD_GUARD: begin
                cnt_n = cnt + 5'd1;
                if (cnt == GUARD_LAST) begin
                    state_n = ST_PACKET;
                    cnt_n   = 5'd0;
                    pkt_n   = 5'd1;
                end
            end
            ST_PACKET: begin
                cnt_n = cnt + 5'd1;
                if (cnt == PKT_LAST) begin
                    cnt_n = 5'd0;
                    if (pkt == num_pkts) state_n = ST_TRAIL_GUARD;
                    else                 pkt_n   = pkt + 5'd1;
                end
            end
            ST_TRAIL_GUARD: begin
                cnt_n = cnt + 5'd1;
                if (cnt == GUARD_LAST) begin
                    state_n = ST_IDLE;
                    cnt_n   = 5'd0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Video returning early wins over any island progress.
        if (video_active && in_island) begin
            state_n = ST_ACTIVE;
            cnt_n   = 5'd0;
            pkt_n   = 5'd0;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state                <= ST_IDLE;
            cnt                  <= 5'd0;
            pkt                  <= 5'd0;
            num_pkts             <= 5'd0;
            island_preamble      <= 1'b0;
            data_guard           <= 1'b0;
            data_island_period   <= 1'b0;
            packet_enable        <= 1'b0;
            packet_pixel_counter <= 5'd0;
            schedule_error       <= 1'b0;
        end else begin
            state                <= state_n;
            cnt                  <= cnt_n;
            pkt                  <= pkt_n;
            num_pkts             <= num_pkts_n;
            island_preamble      <= (state_n == ST_PREAMBLE);
            data_guard           <= (state_n == ST_LEAD_GUARD) || (state_n == ST_TRAIL_GUARD);
            data_island_period   <= (state_n == ST_PACKET);
            packet_pixel_counter <= (state_n == ST_PACKET) ? cnt_n : 5'd0;
            packet_enable        <= ((state_n == ST_LEAD_GUARD) && (cnt_n == GUARD_LAST)) ||
                                    ((state_n == ST_PACKET) && (cnt_n == PKT_LAST) &&
                                     (pkt_n != num_pkts_n));
            schedule_error       <= err_n;
        end
    end

endmodule

// File: tb/tb_hdmi_data_island_scheduler.sv
// Self-checking bench: table-driven and randomized blanking lines against a
// cycle-offset reference model, plus abort and mid-island reset sequences.
module tb_hdmi_data_island_scheduler;

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic        enable;
    logic        video_active;
    logic [15:0] blank_cycles_left;
    logic        island_preamble;
    logic        data_guard;
    logic        data_island_period;
    logic        packet_enable;
    logic [4:0]  packet_pixel_counter;
    logic        schedule_error;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit en;
        bit en_after;
        int b_dec;
        int blank_len;
        int exp_strobes;
    } vec_t;

    vec_t vecs[$];

    hdmi_data_island_scheduler dut (
        .clk_pixel           (clk_pixel),
        .reset               (reset),
        .enable              (enable),
        .video_active        (video_active),
        .blank_cycles_left   (blank_cycles_left),
        .island_preamble     (island_preamble),
        .data_guard          (data_guard),
        .data_island_period  (data_island_period),
        .packet_enable       (packet_enable),
        .packet_pixel_counter(packet_pixel_counter),
        .schedule_error      (schedule_error)
    );

    always #5 clk_pixel = ~clk_pixel;

    function automatic int model_budget(input int b);
        int s;
        s = b - 13 - 22;
        if (s < 0) s = 0;
        s = s / 32;
        return (s > 18) ? 18 : s;
    endfunction

    function automatic logic [15:0] dut_outputs();
        return 16'({island_preamble, data_guard, data_island_period, packet_enable,
                    packet_pixel_counter, schedule_error});
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s idx=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    // One blanking interval of blank_len cycles followed by vid_len video cycles.
    // Index i counts cycles from the first blanking cycle; B at the decision
    // cycle (index 11) equals b_dec.
    task automatic applyStimulus(input bit armed, input bit en, input bit en_after,
                                 input int b_dec, input int blank_len, input int vid_len,
                                 input int exp_strobes);
        int  n;
        int  len;
        bit  sched;
        bit  abort;
        int  strobes;
        int  model_strobes;
        n             = model_budget(b_dec);
        sched         = armed && en && (blank_len >= 12) && (n >= 1);
        len           = 12 + 32 * n;
        abort         = sched && (blank_len < 12 + len);
        strobes       = 0;
        model_strobes = 0;
        for (int i = 0; i < blank_len + vid_len; i++) begin
            logic       pre, guard, dip, pe, err;
            logic [4:0] pcnt;
            int         o;
            @(posedge clk_pixel);
            #1;
            o = i - 12;
            pre = 0; guard = 0; dip = 0; pe = 0; err = 0; pcnt = 5'd0;
            if (sched && o >= 0 && o < len && !(abort && i > blank_len)) begin
                pre   = (o < 8);
                guard = (o == 8) || (o == 9) || (o >= len - 2);
                dip   = (o >= 10) && (o < len - 2);
                if (dip) pcnt = 5'((o - 10) % 32);
                pe    = (o == 9) || (dip && ((o - 10) % 32 == 31) && ((o - 10) / 32 < n - 1));
            end
            if (abort && i == blank_len + 1) err = 1;
            if (pe) model_strobes++;
            checkOutput("cycle", i, dut_outputs(), 16'({pre, guard, dip, pe, pcnt, err}));
            if (packet_enable) strobes++;
            video_active      = (i >= blank_len);
            enable            = (i <= 11) ? en : en_after;
            blank_cycles_left = (i < blank_len) ? 16'(b_dec + 11 - i) : 16'($urandom);
        end
        checkOutput("strobes", blank_len, 16'(strobes),
                    16'((exp_strobes >= 0) ? exp_strobes : model_strobes));
    endtask

    initial begin
        vecs.push_back('{1, 1,  100,  111,  2});
        vecs.push_back('{1, 0,  100,  111,  2});
        vecs.push_back('{1, 1, 5000, 5011, 18});
        vecs.push_back('{1, 1,   66,   77,  0});
        vecs.push_back('{0, 1,  100,  111,  0});
        vecs.push_back('{1, 1,   67,   78,  1});
        vecs.push_back('{1, 1,   98,  109,  1});
        vecs.push_back('{1, 1,   99,  110,  2});
        vecs.push_back('{1, 1,  611,  622, 18});
        vecs.push_back('{1, 1,  200,    8,  0});
        vecs.push_back('{1, 1,  100,   32,  1});
        vecs.push_back('{1, 1,  100,  111,  2});

        reset             = 1'b1;
        enable            = 1'b0;
        video_active      = 1'b0;
        blank_cycles_left = 16'd0;
        #12;
        checkOutput("reset", 0, dut_outputs(), 16'd0);
        @(posedge clk_pixel);
        #1 reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk_pixel);
            #1;
            checkOutput("lead_video", i, dut_outputs(), 16'd0);
            video_active = 1'b1;
        end

        foreach (vecs[k])
            applyStimulus(1, vecs[k].en, vecs[k].en_after, vecs[k].b_dec,
                          vecs[k].blank_len, 4, vecs[k].exp_strobes);

        for (int k = 0; k < 20; k++) begin
            int b, bl;
            b  = $urandom_range(20, 700);
            bl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 11) : b + 11;
            applyStimulus(1, ($urandom_range(0, 3) != 0), 1'($urandom), b, bl,
                          $urandom_range(2, 6), -1);
        end

        // Reset in the middle of packet 1, then blanking with no prior video.
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_pixel);
            #1;
            video_active      = 1'b0;
            enable            = 1'b1;
            blank_cycles_left = 16'(111 - i);
        end
        @(posedge clk_pixel);
        #1;
        checkOutput("pre_reset_packet", 30,
                    16'({data_island_period, packet_pixel_counter}), 16'({1'b1, 5'd8}));
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset", 30, dut_outputs(), 16'd0);
        @(posedge clk_pixel);
        @(posedge clk_pixel);
        #1 reset = 1'b0;
        applyStimulus(0, 1, 1, 100, 111, 4, 0);
        applyStimulus(1, 1, 1, 100, 111, 4, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
